// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// One byte per grant: strobe the transmitter, then wait for done or watchdog abort.
module uart_tx_arbiter #(
    parameter int          NREQ    = 4,
    parameter int          DBIT    = 8,
    parameter int unsigned TIMEOUT = 200000,
    localparam int         GW      = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*DBIT-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    // state | meaning
    // IDLE  | arbitrate; accept a byte from the round-robin winner
    // START | one-cycle start strobe to the transmitter, watchdog cleared
    // WAIT  | wait for done tick or watchdog expiry
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_last;
    logic [GW-1:0]     r_grant;
    logic [DBIT-1:0]   r_tx_din;
    logic              r_tx_start;
    logic              r_busy;
    logic              r_timeout_err;
    logic [31:0]       r_cnt;

    logic              w_found;
    logic [GW-1:0]     w_winner;
    logic [GW-1:0]     w_idx;
    logic              w_accept;
    logic              w_abort;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_found     = 1'b0;
        w_winner    = '0;
        w_idx       = '0;
        // search upward from last+1 so the most recently served requester comes last
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = GW'((int'(r_last) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    w_accept            = 1'b1;
                    w_state_nxt         = S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // a done tick coinciding with expiry counts as success
                if (tx_done_tick) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == TIMEOUT - 1) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last        <= GW'(NREQ - 1);
            r_grant       <= '0;
            r_tx_din      <= '0;
            r_tx_start    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_tx_start    <= w_accept;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_timeout_err <= w_abort;
            if (w_accept) begin
                r_tx_din <= req_data[int'(w_winner)*DBIT +: DBIT];
                r_grant  <= w_winner;
                r_last   <= w_winner;
            end
            if (r_state == S_START)
                r_cnt <= '0;
            else if (r_state == S_WAIT && !tx_done_tick && !w_abort)
                r_cnt <= r_cnt + 32'd1;
        end
    end

    assign tx_start    = r_tx_start;
    assign tx_din      = r_tx_din;
    assign grant_id    = r_grant;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: scoreboard of expected bytes popped on tx_start,
// plus a second instance with a short watchdog.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    logic [3:0]  v2 = '0;
    logic [31:0] d2 = '0;
    logic [3:0]  rdy2;
    logic        start2;
    logic [7:0]  din2;
    logic        done2 = 1'b0;
    logic [1:0]  gid2;
    logic        busy2;
    logic        to2;

    int    n_chk = 0;
    int    n_pass = 0;
    int    to_lat;
    exp_t  sb[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din),
        .tx_done_tick(tx_done_tick), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(8)) dut_to (
        .clk(clk), .reset_n(reset_n), .req_valid(v2), .req_data(d2),
        .req_ready(rdy2), .tx_start(start2), .tx_din(din2),
        .tx_done_tick(done2), .grant_id(gid2), .busy(busy2),
        .timeout_err(to2)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    // scoreboard consumer: every start strobe must match the oldest expected grant
    always @(negedge clk) begin
        if (reset_n && tx_start) begin
            if (sb.size() == 0) begin
                chk_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("tx_din", 32'(tx_din), 32'(e.data));
                chk_eq("grant_id", 32'(grant_id), 32'(e.id));
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    // called in an IDLE cycle with inputs already applied
    task automatic grant_cycle(input logic [3:0] exp_rdy, input int id,
                               input logic [7:0] data, input int dly);
        #1;
        chk_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        push_exp(id, data);
        @(negedge clk); #1;
        chk_eq("tx_start", 32'(tx_start), 32'd1);
        chk_eq("busy_start", 32'(busy), 32'd1);
        chk_eq("ready_in_start", 32'(req_ready), 32'd0);
        repeat (dly) @(negedge clk);
        chk_eq("busy_wait", 32'(busy), 32'd1);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        #1;
        chk_eq("busy_after_done", 32'(busy), 32'd0);
        chk_eq("start_after_done", 32'(tx_start), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset();
        #1;
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_start", 32'(tx_start), 32'd0);
        chk_eq("rst_din", 32'(tx_din), 32'd0);
        chk_eq("rst_gid", 32'(grant_id), 32'd0);
        chk_eq("rst_to", 32'(timeout_err), 32'd0);

        // single requester 2, done 20 cycles after start
        req_valid = 4'b0100;
        req_data  = 32'h005A_0000;
        grant_cycle(4'b0100, 2, 8'h5A, 20);
        req_valid = '0;

        // all valid: rotation 0,1,2,3,0
        do_reset();
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        for (int g = 0; g < 5; g++)
            grant_cycle(4'(1 << (g % 4)), g % 4, 8'(8'h10 + (g % 4)), 5);
        req_valid = '0;

        // 1 served, then 1 and 3 contend: 3 first, then 1
        do_reset();
        req_data  = 32'hD3C2_B1A0;
        req_valid = 4'b0010;
        grant_cycle(4'b0010, 1, 8'hB1, 3);
        req_valid = 4'b1010;
        grant_cycle(4'b1000, 3, 8'hD3, 3);
        grant_cycle(4'b0010, 1, 8'hB1, 3);
        req_valid = '0;

        // watchdog instance, TIMEOUT=8
        v2 = 4'b0001;
        d2 = 32'h0000_00A1;
        #1;
        chk_eq("to_ready", 32'(rdy2), 32'b0001);
        @(negedge clk);
        v2 = '0;
        #1;
        chk_eq("to_start", 32'(start2), 32'd1);
        chk_eq("to_din", 32'(din2), 32'hA1);
        to_lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (to2) begin
                to_lat = i;
                break;
            end
        end
        chk_eq("to_latency", 32'(to_lat), 32'd9);
        chk_eq("to_busy", 32'(busy2), 32'd0);
        @(negedge clk);
        chk_eq("to_single_pulse", 32'(to2), 32'd0);
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        #1;
        chk_eq("late_done_busy", 32'(busy2), 32'd0);
        chk_eq("late_done_start", 32'(start2), 32'd0);
        v2 = 4'b0010;
        d2 = 32'h0000_B200;
        #1;
        chk_eq("to_regrant_ready", 32'(rdy2), 32'b0010);
        @(negedge clk);
        v2 = '0;
        #1;
        chk_eq("to_regrant_din", 32'(din2), 32'hB2);
        chk_eq("to_regrant_gid", 32'(gid2), 32'd1);
        // done coinciding with expiry: success, no error
        repeat (8) @(negedge clk);
        done2 = 1'b1;
        @(negedge clk);
        done2 = 1'b0;
        #1;
        chk_eq("done_at_expiry_to", 32'(to2), 32'd0);
        chk_eq("done_at_expiry_busy", 32'(busy2), 32'd0);

        // reset mid-WAIT after serving requester 1
        req_data  = 32'hE3E2_E1E0;
        req_valid = 4'b0010;
        #1;
        chk_eq("pre_rst_ready", 32'(req_ready), 32'b0010);
        push_exp(1, 8'hE1);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        reset_n   = 1'b0;
        req_valid = 4'b1001;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_eq("mid_rst_busy", 32'(busy), 32'd0);
        chk_eq("mid_rst_start", 32'(tx_start), 32'd0);
        chk_eq("mid_rst_din", 32'(tx_din), 32'd0);
        chk_eq("mid_rst_gid", 32'(grant_id), 32'd0);
        chk_eq("mid_rst_to", 32'(timeout_err), 32'd0);
        grant_cycle(4'b0001, 0, 8'hE0, 4);
        req_valid = '0;

        // done tick during START is ignored
        req_valid = 4'b0100;
        #1;
        chk_eq("st_ready", 32'(req_ready), 32'b0100);
        push_exp(2, 8'hE2);
        @(negedge clk);
        req_valid    = '0;
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        #1;
        chk_eq("st_done_ignored", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        chk_eq("st_still_busy", 32'(busy), 32'd1);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        #1;
        chk_eq("st_final_idle", 32'(busy), 32'd0);

        @(negedge clk);
        chk_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among NREQ byte producers. It accepts one byte at a time from the requesters over a valid/ready handshake, issues a single-cycle start strobe with the latched byte to the transmitter, and waits for the transmitter's done tick before serving the next requester. A watchdog returns the block to idle if the transmitter never reports completion. It sits between the system's byte sources (command responder, status reporter, debug logger, …) and the UART TX datapath, which runs on the same clk and baud-tick scheme as the receiver.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- DBIT, 8, data bits per frame; must match the transmitter
- TIMEOUT, 200000, clk cycles allowed in WAIT before abort; legal range 1..2^32-1
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  bit i set: requester i holds a byte
- req_data  in  NREQ*DBIT  requester i byte at bits [i*DBIT +: DBIT]
- req_ready  out  NREQ  one-hot; bit i high: byte i accepted this cycle
- tx_start  out  1  one-cycle strobe to the transmitter
- tx_din  out  DBIT  byte to transmit; stable from tx_start until return to IDLE
- tx_done_tick  in  1  one-cycle pulse from the transmitter at end of stop bit
- grant_id  out  GW=$clog2(NREQ)  index of the requester being served
- busy  out  1  high in START and WAIT
- timeout_err  out  1  one-cycle pulse when the watchdog aborts

## Operation
- States: IDLE, START, WAIT (2-bit encoding).
- IDLE:
  - Winner is the first requester with req_valid high, searching upward from last+1 modulo NREQ.
  - If a winner exists: req_ready[winner]=1 combinationally (the only output driven this way); on the next edge latch tx_din, grant_id=winner, last=winner, and go to START.
  - If no requester is valid: req_ready=0 and the block stays in IDLE.
- START: tx_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - On tx_done_tick: go to IDLE.
  - Else, if the counter equals TIMEOUT-1: pulse timeout_err and go to IDLE.
  - Else: increment the counter (32-bit, no wrap possible before the compare).
- tx_done_tick is ignored in IDLE and START. A done tick and timeout in the same cycle count as success: no timeout_err.
- req_ready is 0 in START and WAIT regardless of req_valid.
- A requester may drop req_valid before it is granted without side effects. Its data must be stable only in the cycle valid and ready are both high.
- Round robin: a requester that was just served has the lowest priority in the next arbitration. With all requesters continuously valid, grants rotate 0,1,2,…,NREQ-1,0.
- The last pointer updates only on an accepted byte, not on timeout or reset-free idle cycles.
- Reset (any state, including mid-WAIT):
  - State IDLE; tx_start=0, tx_din=0, grant_id=0, busy=0, timeout_err=0, counter=0.
  - last=NREQ-1, so requester 0 has first priority after reset.
  - An in-flight byte is dropped with no done or error indication.
  - A combinational req_ready may be high during the reset cycle but must not cause a state change.

## Timing
- Cycle 0 (IDLE, valid seen): req_ready pulses for the winner.
- Cycle 1: tx_start=1 and busy=1; tx_din and grant_id are valid.
- Cycle 2 onward: WAIT.
- Done tick at cycle k: IDLE at cycle k+1, when a new grant is possible.
- Minimum spacing between consecutive tx_start pulses: transmitter frame time + 3 cycles.
- Timeout: with no done tick, timeout_err pulses in the cycle TIMEOUT+1 after tx_start, and the block is in IDLE the following cycle.
- busy: registered; high from cycle 1 until the cycle after done or timeout.

## Test plan
- Reset then req_valid=4'b0100, data2=0x5A -> req_ready=4'b0100 in the same cycle, tx_start one cycle later with tx_din=0x5A and grant_id=2; done tick 20 cycles later -> busy low the next cycle.
- All four requesters continuously valid with data 0x10..0x13, done tick 5 cycles after each start -> tx_din sequence 0x10,0x11,0x12,0x13,0x10; exactly one req_ready bit per grant.
- Requester 1 served, then requesters 1 and 3 both valid -> requester 3 granted first, then requester 1.
- TIMEOUT=8 with no done tick -> timeout_err pulses once, 9 cycles after tx_start; next valid request is granted; a late done tick arriving in IDLE is ignored.
- reset_n low for one cycle mid-WAIT -> all outputs at reset values; requester 0 wins the next arbitration against requester 3.
- Done tick in START, then no done in WAIT -> no return to IDLE until the later done tick or timeout.
